// File: rtl/cpu8_pkg.sv
// Shared types for the 8-bit datapath: widths, ALU opcodes,
// instruction field positions and the decode-to-execute bundle.
package cpu8_pkg;

   localparam int DATA_W   = 8;
   localparam int NUM_REGS = 4;
   localparam int REG_AW   = 2;

   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 6;
   localparam int RD_MSB  = 5;
   localparam int RD_LSB  = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 2;
   localparam int IMM_MSB = 1;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_SLL = 2'b10,
      ALU_AND = 2'b11
   } alu_op_e;

   typedef struct packed {
      alu_op_e             op;
      logic [REG_AW-1:0]   rd;
      logic [1:0]          imm;
      logic [DATA_W-1:0]   d1;
      logic [DATA_W-1:0]   d2;
   } id_ex_t;

endpackage

// File: rtl/regfile_4x8.sv
// 4 x 8-bit register file: two combinational read ports, one write port.
// Ports: ra1/ra2 -> rd1/rd2 reads; we/wa/wd write. WB_BYPASS_EN forwards wd.
module regfile_4x8
   import cpu8_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = regs[ra1];
      rd2 = regs[ra2];
`ifdef WB_BYPASS_EN
      // same-cycle writeback is visible to the reader
      if (we && (wa == ra1)) rd1 = wd;
      if (we && (wa == ra2)) rd2 = wd;
`endif
   end

endmodule

// File: rtl/decode_stage.sv
// Decode + operand fetch with a per-register pending scoreboard.
// Ports: instr valid/ready in, ex_* slot valid/ready out, wb_* writeback in. Option: WB_BYPASS_EN.
module decode_stage
   import cpu8_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [7:0]        instr,
   output logic              instr_ready,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] rs_data1,
   output logic [DATA_W-1:0] rs_data2,
   output logic [1:0]        immediate,
   output logic [1:0]        alu_op,
   output logic [REG_AW-1:0] ex_rd,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   logic [REG_AW-1:0]   f_rd;
   logic [REG_AW-1:0]   f_rs2;
   logic [1:0]          f_imm;
   alu_op_e             f_op;
   logic [DATA_W-1:0]   rd1;
   logic [DATA_W-1:0]   rd2;
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pend_chk;
   logic [NUM_REGS-1:0] pending_n;
   logic                hazard;
   logic                accept;
   id_ex_t              slot;

   assign f_op  = alu_op_e'(instr[OP_MSB:OP_LSB]);
   assign f_rd  = instr[RD_MSB:RD_LSB];
   assign f_rs2 = instr[RS2_MSB:RS2_LSB];
   assign f_imm = instr[IMM_MSB:IMM_LSB];

   regfile_4x8 u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (f_rd),
      .ra2   (f_rs2),
      .rd1   (rd1),
      .rd2   (rd2),
      .we    (wb_en),
      .wa    (wb_addr),
      .wd    (wb_data)
   );

   always_comb begin
      pend_chk = pending;
`ifdef WB_BYPASS_EN
      // the forwarded value resolves the dependency now
      if (wb_en) pend_chk[wb_addr] = 1'b0;
`endif
   end

   assign hazard      = pend_chk[f_rd] | pend_chk[f_rs2];
   assign instr_ready = (!ex_valid || ex_ready) && !hazard;
   assign accept      = instr_valid && instr_ready;

   // set after clear: a new owner of rd wins over a retiring one
   always_comb begin
      pending_n = pending;
      if (wb_en)  pending_n[wb_addr] = 1'b0;
      if (accept) pending_n[f_rd]    = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         ex_valid <= 1'b0;
         slot     <= '0;
      end else begin
         pending <= pending_n;
         if (accept) begin
            ex_valid <= 1'b1;
            slot.op  <= f_op;
            slot.rd  <= f_rd;
            slot.imm <= f_imm;
            slot.d1  <= rd1;
            slot.d2  <= rd2;
         end else if (ex_ready) begin
            ex_valid <= 1'b0;
         end
      end
   end

   assign alu_op    = slot.op;
   assign ex_rd     = slot.rd;
   assign immediate = slot.imm;
   assign rs_data1  = slot.d1;
   assign rs_data2  = slot.d2;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed stimulus, queue of expected slots.
// A negedge monitor pops and compares each slot as it is consumed.
module tb_decode_stage;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       instr_valid = 1'b0;
   logic [7:0] instr = '0;
   logic       instr_ready;
   logic       ex_valid;
   logic       ex_ready = 1'b1;
   logic [7:0] rs_data1;
   logic [7:0] rs_data2;
   logic [1:0] immediate;
   logic [1:0] alu_op;
   logic [1:0] ex_rd;
   logic       wb_en = 1'b0;
   logic [1:0] wb_addr = '0;
   logic [7:0] wb_data = '0;

   int n_chk = 0;
   int n_fail = 0;
   logic [21:0] sb [$];
   logic [21:0] mon_e;

`ifdef WB_BYPASS_EN
   localparam logic [7:0] D_SW_D1 = 8'd20;
`else
   localparam logic [7:0] D_SW_D1 = 8'd15;
`endif

   decode_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .rs_data1    (rs_data1),
      .rs_data2    (rs_data2),
      .immediate   (immediate),
      .alu_op      (alu_op),
      .ex_rd       (ex_rd),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [21:0] pk(logic [7:0] i, logic [7:0] d1,
                                      logic [7:0] d2);
      return {i[7:6], i[5:4], i[1:0], d1, d2};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n && ex_valid && ex_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL slot_unexpected: got %0h expected none",
                     {alu_op, ex_rd, immediate, rs_data1, rs_data2});
         end else begin
            mon_e = sb.pop_front();
            chk("slot", {alu_op, ex_rd, immediate, rs_data1, rs_data2}, mon_e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1 rst_n = 1'b0;
      #11;
      chk("rst_valid", ex_valid, 0);
      chk("rst_ready", instr_ready, 1);
      chk("rst_d1", rs_data1, 0);
      chk("rst_d2", rs_data2, 0);
      chk("rst_fields", {immediate, alu_op, ex_rd}, 0);
      neg();
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", instr_ready, 1);

      // r1 = 10, r2 = 5
      wb_en = 1; wb_addr = 1; wb_data = 10;
      step();
      wb_addr = 2; wb_data = 5;
      step();
      wb_en = 0;

      // basic issue ADD r1,r2
      instr = 8'b00_01_10_00; instr_valid = 1;
      neg();
      chk("a_ready", instr_ready, 1);
      sb.push_back(pk(instr, 10, 5));
      step();
      instr_valid = 0;
      neg();
      chk("a_valid", ex_valid, 1);
      chk("a_d1", rs_data1, 10);
      chk("a_d2", rs_data2, 5);
      chk("a_op", alu_op, 0);
      chk("a_rd", ex_rd, 1);
      step();
      wb_en = 1; wb_addr = 1; wb_data = 10;
      step();
      wb_en = 0;

      // back-pressure
      ex_ready = 0;
      instr = 8'b11_10_11_01; instr_valid = 1;
      neg();
      chk("b_ready", instr_ready, 1);
      sb.push_back(pk(instr, 5, 0));
      step();
      instr = 8'b01_00_00_10;
      repeat (3) begin
         neg();
         chk("b_stall", instr_ready, 0);
         chk("b_hold_valid", ex_valid, 1);
         chk("b_hold_data", {rs_data1, rs_data2}, 16'h0500);
         chk("b_hold_fields", {alu_op, ex_rd, immediate}, 6'b11_10_01);
         step();
      end
      ex_ready = 1;
      neg();
      chk("b_accept", instr_ready, 1);
      sb.push_back(pk(instr, 0, 0));
      step();
      instr_valid = 0;
      neg();
      chk("b_new_op", alu_op, 1);
      step();
      wb_en = 1; wb_addr = 2; wb_data = 5;
      step();
      wb_addr = 0; wb_data = 0;
      step();
      wb_en = 0;

      // RAW: SUB r1,r2 then ADD r3,r1
      instr = 8'b01_01_10_00; instr_valid = 1;
      neg();
      chk("c_sub_ready", instr_ready, 1);
      sb.push_back(pk(instr, 10, 5));
      step();
      instr = 8'b00_11_01_00;
      repeat (3) begin
         neg();
         chk("c_raw_stall", instr_ready, 0);
         step();
      end
      wb_en = 1; wb_addr = 1; wb_data = 15;
      neg();
`ifdef WB_BYPASS_EN
      chk("c_bypass_ready", instr_ready, 1);
      sb.push_back(pk(instr, 0, 15));
      step();
      wb_en = 0; instr_valid = 0;
`else
      chk("c_wb_cycle_stall", instr_ready, 0);
      step();
      wb_en = 0;
      neg();
      chk("c_late_ready", instr_ready, 1);
      sb.push_back(pk(instr, 0, 15));
      step();
      instr_valid = 0;
`endif
      neg();
      chk("c_d2", rs_data2, 15);
      step();
      wb_en = 1; wb_addr = 3; wb_data = 7;
      step();
      wb_en = 0;

      // set-wins: wb r1 while SLL r1,r0 issues
      instr = 8'b10_01_00_11; instr_valid = 1;
      wb_en = 1; wb_addr = 1; wb_data = 20;
      neg();
      chk("d_ready", instr_ready, 1);
      sb.push_back(pk(instr, D_SW_D1, 0));
      step();
      wb_en = 0;
      instr = 8'b00_00_01_00;
      repeat (2) begin
         neg();
         chk("d_setwins_stall", instr_ready, 0);
         step();
      end

      // async reset with a held slot and pending[1]
      ex_ready = 0;
      instr = 8'b00_10_11_00;
      neg();
      chk("e_ready", instr_ready, 1);
      step();
      instr_valid = 0;
      instr = 8'b00_00_01_00;
      neg();
      chk("e_valid", ex_valid, 1);
      chk("e_d2", rs_data2, 7);
      chk("e_pend_stall", instr_ready, 0);
      #2 rst_n = 0;
      #1;
      chk("e_rst_valid", ex_valid, 0);
      chk("e_rst_d1", rs_data1, 0);
      chk("e_rst_ready", instr_ready, 1);
      neg();
      rst_n = 1;
      ex_ready = 1;
      step();
      instr = 8'b00_01_10_00; instr_valid = 1;
      neg();
      chk("e_post_ready", instr_ready, 1);
      sb.push_back(pk(instr, 0, 0));
      step();
      instr_valid = 0;
      neg();
      step();
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and operand-fetch stage of the 8-bit datapath, sitting directly upstream of the ALU. It accepts one 8-bit instruction per cycle, splits it into ALU opcode, destination/source registers and a 2-bit immediate, and reads operands from an internal 4 x 8-bit register file. It presents them to the execute stage in a registered valid/ready slot. A per-register scoreboard stalls read-after-write and write-after-write hazards until the writeback port returns the result.

## Interface
- DATA_W, 8, register and operand width
- NUM_REGS, 4, register count; the register address is 2 bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction available
- instr  in  8  [7:6] alu_op (00 ADD, 01 SUB, 10 SLL, 11 AND); [5:4] rd (also source 1); [3:2] rs2; [1:0] immediate
- instr_ready  out  1  instruction accepted this cycle when high together with instr_valid
- ex_valid  out  1  execute slot holds a valid instruction
- ex_ready  in  1  execute stage consumes the slot
- rs_data1  out  DATA_W  value of rd at issue
- rs_data2  out  DATA_W  value of rs2 at issue
- immediate  out  2  instr[1:0]
- alu_op  out  2  instr[7:6]
- ex_rd  out  2  destination register
- wb_en  in  1  writeback strobe
- wb_addr  in  2  writeback register
- wb_data  in  DATA_W  writeback value

## Operation
- Two-operand ISA: rd <- rd op rs2, so source 1 is the rd field.
- Hazard: set when pending[rd] or pending[rs2] is 1, after bypass adjustment.
- instr_ready = (!ex_valid || ex_ready) && !hazard.
- Accept (instr_valid && instr_ready):
  - Load the decoded fields and operands into the slot.
  - Set ex_valid = 1.
  - Set pending[rd] = 1.
- ex_valid && ex_ready without an accept: clear ex_valid; the slot data holds its last value.
- ex_valid && !ex_ready: all ex_* outputs, rs_data*, immediate and alu_op hold stable.
- Writeback:
  - wb_en writes regs[wb_addr] <= wb_data on the clock edge.
  - wb_en clears pending[wb_addr].
  - A write to a non-pending register is legal; the register file updates and pending stays 0.
- Simultaneous writeback clear and accept-set on the same register: the set wins, so pending stays 1.
- Register reads are combinational at accept time; see Configuration for the same-cycle writeback case.
- Reset:
  - All regs = 0, pending = 0.
  - ex_valid = 0, rs_data1/rs_data2 = 0, immediate/alu_op/ex_rd = 0.
  - instr_ready is 1 after reset, because it is combinational with ex_valid = 0 and no pending registers.
- Reset asserted mid-operation discards the slot and all pending bits immediately, without waiting for a clock edge.

## Timing
- Latency: an instruction accepted at edge N is visible on the ex_* outputs after edge N, i.e. one cycle.
- Throughput: one instruction per cycle when there are no hazards and ex_ready = 1.
- instr_ready is combinational from ex_valid, ex_ready, pending, instr, wb_en and wb_addr; it has no combinational dependence on instr_valid.
- Scoreboard and register file update on the same edge as the writeback.

## Configuration
- WB_BYPASS_EN defined:
  - A read of a register whose address equals wb_addr while wb_en = 1 returns wb_data.
  - That register counts as not pending for the hazard check, so a dependent instruction issues in the writeback cycle.
- WB_BYPASS_EN undefined:
  - Reads return the pre-write register value.
  - Hazard uses raw pending, so a dependent instruction issues one cycle after the writeback.

## Structure
- Package cpu8_pkg holds:
  - DATA_W
  - alu_op enumeration (ALU_ADD, ALU_SUB, ALU_SLL, ALU_AND)
  - instruction field bit positions
- Sub-module regfile_4x8:
  - two combinational read ports and one write port
  - asynchronous active-low reset clears all registers
  - WB_BYPASS_EN bypass logic lives inside it
- The scoreboard and slot register live in decode_stage.

## Test plan
- Reset: rst_n low then high -> ex_valid = 0, instr_ready = 1, all data outputs 0.
- Write r1 = 10 and r2 = 5 via wb, then issue instr = 8'b00_01_10_00 -> next cycle ex_valid = 1, rs_data1 = 10, rs_data2 = 5, alu_op = 00, ex_rd = 1.
- Back-pressure: hold ex_ready = 0 for 3 cycles with a new instr_valid -> slot outputs stable and instr_ready = 0 throughout; raise ex_ready -> the new instruction is accepted that cycle.
- RAW hazard: issue SUB r1,r2, then ADD r3,r1 (8'b00_11_01_00) -> instr_ready stays 0 until wb r1 = 15.
  - With WB_BYPASS_EN: accepted in the wb cycle with rs_data2 = 15.
  - Without it: accepted one cycle later with rs_data2 = 15.
- Set-wins: wb r1 in the same cycle an instruction with rd = 1 is accepted -> pending[1] = 1, and the next reader of r1 stalls.
- Async reset mid-flight: with ex_valid = 1 and pending[1] = 1, drop rst_n between clock edges -> ex_valid = 0 immediately, regs = 0, and instr_ready = 1 after release.
